axis_uart_tx_arb: RTL and testbench
===================================

AXIS_UART_TX_ARB -- requirements
Module: axis_uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of AXI-Stream byte sources sharing one UART transmitter (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one UART character.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_async_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_tdata, input, NUM_SRC*DATA_WIDTH bits: source i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports s_tvalid, s_tlast (input) and s_tready (output), each NUM_SRC bits: per-source handshake and end-of-packet.
REQ-007 SHALL have ports m_tdata (output, DATA_WIDTH), m_tvalid (output, 1), m_tlast (output, 1) and m_tready (input, 1), connected to the tdata/tvalid/tready of axis_uart_tx.
REQ-008 SHALL have port grant, output, NUM_SRC bits: one-hot current owner, all-zero when idle.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is GRANT.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 In IDLE, grant, m_tvalid and s_tready SHALL be all-zero.
REQ-012 In IDLE with any s_tvalid high, the block SHALL select the first requester searching upward from (rr_ptr+1) mod NUM_SRC, register it as grant, and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-013 In GRANT with owner g: m_tdata, m_tvalid and m_tlast SHALL combinationally equal s_tdata[g], s_tvalid[g] and s_tlast[g]; s_tready[g] SHALL equal m_tready; all other s_tready bits SHALL be 0.
REQ-014 A transfer SHALL occur only on a cycle where m_tvalid and m_tready are both high.
REQ-015 On a transfer, rr_ptr SHALL load g, and the release rule (Configuration) decides whether the state returns to IDLE.
REQ-016 Non-owner requests arriving during GRANT SHALL be ignored until the next IDLE cycle; this must not cause loss or duplication of any byte.
REQ-017 Grant SHALL never change while m_tvalid is high and m_tready is low; m_tdata SHALL be stable for as long as the source holds it.
REQ-018 rr_ptr SHALL be $clog2(NUM_SRC) bits wide and wrap from NUM_SRC-1 to 0.
REQ-019 A single requester SHALL achieve one byte per two clocks at most (IDLE and GRANT alternate), which is ample for UART rates.

Reset
REQ-020 While rst_async_n is low, the state SHALL be IDLE, grant 0, busy 0, m_tvalid 0, m_tlast 0, m_tdata 0, s_tready 0, and rr_ptr NUM_SRC-1, so that source 0 wins first.
REQ-021 Reset asserted mid-packet SHALL abort the grant immediately (asynchronously), with no further transfer; deassertion SHALL be followed by arbitration at the first edge after release.

Configuration
REQ-022 Macro UART_ARB_PKT_LOCK_EN: when defined, GRANT SHALL be left only on a transfer with s_tlast[g]=1; the owner keeps the grant across gaps where s_tvalid[g] is low.
REQ-023 When UART_ARB_PKT_LOCK_EN is undefined, GRANT SHALL return to IDLE after every transfer (per-byte round-robin); s_tlast SHALL only be passed through.

Verification
REQ-024 Reset: hold rst_async_n low for 3 clocks with all s_tvalid high -> all outputs 0 and no s_tready; after release, the first grant is 4'b0001.
REQ-025 Single byte: src2 presents 8'hC5 with m_tready=1 -> grant=4'b0100 one clock later, m_tdata=8'hC5, exactly one transfer, then IDLE; UART out line shows the 8'hC5 frame.
REQ-026 Fairness: src0..3 each present one byte 8'hA0..8'hA3 simultaneously -> m_tdata order A0, A1, A2, A3; src0 is re-requested afterwards and wins only after A3.
REQ-027 Backpressure: m_tready held low 100 clocks with src1 granted -> grant, m_tdata and m_tvalid are stable, and s_tready=0 throughout.
REQ-028 Packet lock: src1 sends 8'h11, 8'h22, 8'h33 (tlast on 8'h33) while src0 holds 8'h00 valid -> with macro, output is 11, 22, 33, 00; without macro, output is 11, 00, 22, (src0's next byte), 33.
REQ-029 Mid-packet reset: with the macro defined, pulse rst_async_n low after 8'h22 -> m_tvalid drops without waiting for an edge, and the next grant after release goes to the lowest-index requester.

Source files
------------

// File: rtl/axis_uart_tx_arb.sv
// Round-robin arbiter: NUM_SRC AXI-Stream byte sources share one UART transmitter.
// Latency: 1 clock of arbitration (IDLE) before the owner's byte is presented (GRANT).
// Backpressure: m_tready passes to the owner's s_tready only; the grant is held while m_tvalid && !m_tready.
//
// Ports:
//   clk, rst_async_n          clock, asynchronous active-low reset
//   s_tdata/tvalid/tlast      per-source byte stream; source i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tready                  per-source ready, only the owner's bit can be high
//   m_tdata/tvalid/tlast      muxed stream to the UART transmitter, m_tready from it
//   grant                     one-hot current owner, zero when idle
//   busy                      high while a source owns the transmitter
//
// Optional feature, macro UART_ARB_PKT_LOCK_EN: hold the grant until a transfer
// with s_tlast set (packet lock). Undefined: release after every transfer.
module axis_uart_tx_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_async_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]     owner, owner_nxt;
  logic [NUM_SRC-1:0]   grant_q, grant_nxt;

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     cur;

  logic                 own_vld;
  logic                 own_last;
  logic [DATA_WIDTH-1:0] own_dat;
  logic                 xfer;
  logic                 pkt_done;

  // State register. Reset leaves rr_ptr on the last source so source 0 wins first.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state   <= IDLE;
      rr_ptr  <= LAST_IDX;
      owner   <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      owner   <= owner_nxt;
      grant_q <= grant_nxt;
    end
  end

  // Round-robin search starting one past the last served source, wrapping at NUM_SRC-1.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cur      = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      cur = (cur == LAST_IDX) ? '0 : cur + 1'b1;
      if (!pick_vld && s_tvalid[cur]) begin
        pick_vld = 1'b1;
        pick_idx = cur;
      end
    end
  end

  // Owner mux. Outputs are gated by state so reset clears them without waiting for an edge.
  always_comb begin
    own_vld  = s_tvalid[owner];
    own_last = s_tlast[owner];
    own_dat  = s_tdata[owner*DATA_WIDTH +: DATA_WIDTH];

    busy     = (state == GRANT);
    grant    = grant_q;
    m_tvalid = busy & own_vld;
    m_tlast  = busy & own_last;
    m_tdata  = busy ? own_dat : '0;
    s_tready = busy ? (grant_q & {NUM_SRC{m_tready}}) : '0;
    xfer     = m_tvalid & m_tready;
  end

`ifdef UART_ARB_PKT_LOCK_EN
  // Owner keeps the transmitter across tvalid gaps until its last byte goes out.
  assign pkt_done = own_last;
`else
  assign pkt_done = 1'b1;
`endif

  // Next-state logic. Non-owner requests are only looked at in IDLE, and a
  // presented byte is never abandoned because GRANT is left only on a transfer.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    grant_nxt  = grant_q;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          owner_nxt = pick_idx;
          grant_nxt = NUM_SRC'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (xfer) begin
          rr_ptr_nxt = owner;
          if (pkt_done) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Directed bench for axis_uart_tx_arb: queue-fed sources, byte order scoreboard.
// Inputs change on the falling edge; handshakes are evaluated 1 ns later.
// Expected orders depend on UART_ARB_PKT_LOCK_EN, matching the build.
module tb_axis_uart_tx_arb;

  localparam int NS = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_async_n;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tlast;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [NS-1:0]     grant;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] srcq [NS][$];   // {tlast, data} per source
  logic [7:0] outq [$];       // bytes seen on the master side
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  axis_uart_tx_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant      (grant),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tlast[i]          = srcq[i][0][8];
        s_tdata[i*DW +: DW] = srcq[i][0][7:0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tlast[i]          = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: record handshakes that the coming rising edge will take, then re-drive.
  task automatic cyc();
    #1;
    for (int i = 0; i < NS; i++)
      if (s_tvalid[i] && s_tready[i]) void'(srcq[i].pop_front());
    if (m_tvalid && m_tready) outq.push_back(m_tdata);
    @(posedge clk);
    @(negedge clk);
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      cyc();
      c++;
    end
    chk("byte_count", outq.size(), n);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, outq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) srcq[i].delete();
    outq.delete();
    drive();
    rst_async_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_async_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_async_n = 1'b0;
    m_tready    = 1'b1;
    s_tvalid    = '0;
    s_tlast     = '0;
    s_tdata     = '0;
    @(negedge clk);

    // Reset with every source requesting, then fairness across A0..A3.
    for (int i = 0; i < NS; i++) srcq[i].push_back({1'b1, 8'(8'hA0 + i)});
    drive();
    repeat (3) @(negedge clk);
    chk("rst_grant",  grant, 4'b0000);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_mlast",  m_tlast, 1'b0);
    chk("rst_mdata",  m_tdata, 8'h00);
    chk("rst_sready", s_tready, 4'b0000);
    rst_async_n = 1'b1;
    cyc();
    chk("first_grant", grant, 4'b0001);
    cyc();
    chk("a0_sent", outq.size(), 1);
    srcq[0].push_back({1'b1, 8'hB0});
    drive();
    run_until(5, 40);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    chk_seq("fair_order");

    // Single byte from source 2.
    outq.delete();
    srcq[2].push_back({1'b1, 8'hC5});
    drive();
    cyc();
    chk("single_grant",  grant, 4'b0100);
    chk("single_mdata",  m_tdata, 8'hC5);
    chk("single_mvalid", m_tvalid, 1'b1);
    chk("single_sready", s_tready, 4'b0100);
    chk("single_busy",   busy, 1'b1);
    cyc();
    chk("single_idle_busy",  busy, 1'b0);
    chk("single_idle_grant", grant, 4'b0000);
    repeat (4) cyc();
    exp_q = '{8'hC5};
    chk_seq("single_out");

    // Backpressure: source 1 held for 100 clocks.
    outq.delete();
    m_tready = 1'b0;
    srcq[1].push_back({1'b1, 8'h5A});
    drive();
    cyc();
    chk("bp_grant", grant, 4'b0010);
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("bp_hold", {grant, m_tvalid, m_tdata, s_tready, busy},
          {4'b0010, 1'b1, 8'h5A, 4'b0000, 1'b1});
    end
    chk("bp_none", outq.size(), 0);
    m_tready = 1'b1;
    cyc();
    exp_q = '{8'h5A};
    chk_seq("bp_out");
    chk("bp_release", grant, 4'b0000);

    // Packet from source 1 racing per-byte requests from source 0.
    do_reset();
    srcq[1].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b0, 8'h22});
    srcq[1].push_back({1'b1, 8'h33});
    drive();
    cyc();
    chk("pkt_grant", grant, 4'b0010);
    srcq[0].push_back({1'b1, 8'h00});
    srcq[0].push_back({1'b1, 8'h01});
    drive();
    run_until(5, 60);
`ifdef UART_ARB_PKT_LOCK_EN
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h01};
`else
    exp_q = '{8'h11, 8'h00, 8'h22, 8'h01, 8'h33};
`endif
    chk_seq("pkt_order");

    // Reset pulse while a byte is being presented.
    do_reset();
    srcq[1].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b0, 8'h22});
    srcq[1].push_back({1'b1, 8'h33});
    drive();
    cyc();
    srcq[0].push_back({1'b1, 8'h00});
    srcq[0].push_back({1'b1, 8'h01});
    srcq[0].push_back({1'b1, 8'h02});
    drive();
`ifdef UART_ARB_PKT_LOCK_EN
    run_until(2, 40);
`else
    run_until(3, 40);
`endif
    chk("mr_last_byte", outq[outq.size()-1], 8'h22);
    for (int i = 0; i < 10 && !(busy && m_tvalid); i++) cyc();
    chk("mr_pre_busy", busy & m_tvalid, 1'b1);
    n = outq.size();
    #2 rst_async_n = 1'b0;
    #1;
    chk("mr_mvalid", m_tvalid, 1'b0);
    chk("mr_busy",   busy, 1'b0);
    chk("mr_grant",  grant, 4'b0000);
    chk("mr_sready", s_tready, 4'b0000);
    cyc();
    cyc();
    chk("mr_no_xfer", outq.size(), n);
    rst_async_n = 1'b1;
    cyc();
    chk("mr_regrant", grant, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
